// File: rtl/gs232c_ras_pkg.sv
// Shared return-address-stack definitions: default geometry (AW matches the BTB target width)
// and the per-cycle stack operation encoding used by the top-level update logic.
package gs232c_ras_pkg;

    localparam int unsigned GS232C_RAS_DEPTH = 8;
    localparam int unsigned GS232C_RAS_AW    = 30;

    typedef enum logic [1:0] {
        RAS_NOP  = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_REPL = 2'd3
    } ras_op_e;

    // A call and a return in the same group replace the top entry in place.
    function automatic ras_op_e ras_op(input logic push, input logic pop);
        ras_op_e op;
        case ({push, pop})
            2'b10:   op = RAS_PUSH;
            2'b01:   op = RAS_POP;
            2'b11:   op = RAS_REPL;
            default: op = RAS_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/gs232c_ras_mem.sv
// Return-address storage: DEPTH x AW register file, async clear, one write port,
// one combinational read port addressed by the current top of stack.
module gs232c_ras_mem
    import gs232c_ras_pkg::*;
#(
    parameter  int unsigned DEPTH = GS232C_RAS_DEPTH,
    parameter  int unsigned AW    = GS232C_RAS_AW,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  logic [AW-1:0] i_wdata,
    input  logic [PW-1:0] i_raddr,
    output logic [AW-1:0] o_rdata
);

    logic [AW-1:0] r_mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gs232c_ras.sv
// Speculative return-address stack for jrra prediction, repaired from a {cnt,tos} checkpoint
// on predecode cancel. Optional same-cycle push forwarding: GS232C_RAS_PUSH_BYPASS_EN.
module gs232c_ras
    import gs232c_ras_pkg::*;
#(
    parameter  int unsigned DEPTH = GS232C_RAS_DEPTH,
    parameter  int unsigned AW    = GS232C_RAS_AW,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iq_go,
    input  logic             iq_cancel,
    input  logic             fe_push,
    input  logic [AW-1:0]    fe_push_pc,
    input  logic             fe_pop,
    output logic [PW+CW-1:0] fe_ckpt,
    input  logic             pr_cancel,
    input  logic [PW+CW-1:0] pr_ckpt,
    input  logic             pr_link,
    input  logic [AW-1:0]    pr_link_pc,
    input  logic             pr_jrra,
    output logic [AW-1:0]    ra,
    output logic             ra_valid
);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0] r_tos;
    logic [CW-1:0] r_cnt;

    logic          w_fe_ok;
    ras_op_e       w_op;
    logic [PW-1:0] w_base_tos;
    logic [CW-1:0] w_base_cnt;
    logic [PW-1:0] w_nxt_tos;
    logic [CW-1:0] w_nxt_cnt;
    logic          w_we;
    logic [PW-1:0] w_wr_addr;
    logic [AW-1:0] w_wr_pc;
    logic [AW-1:0] w_mem_rd;

    // Repair restores {cnt,tos} first, then reuses the same push/pop/replace rules.
    always_comb begin
        w_fe_ok    = iq_go & ~iq_cancel & ~pr_cancel;
        w_base_tos = r_tos;
        w_base_cnt = r_cnt;
        w_wr_pc    = fe_push_pc;
        w_op       = RAS_NOP;
        if (pr_cancel) begin
            w_base_tos = pr_ckpt[PW-1:0];
            w_base_cnt = pr_ckpt[PW +: CW];
            w_wr_pc    = pr_link_pc;
            w_op       = ras_op(pr_link, pr_jrra);
        end else if (w_fe_ok) begin
            w_op = ras_op(fe_push, fe_pop);
        end

        w_nxt_tos = w_base_tos;
        w_nxt_cnt = w_base_cnt;
        w_we      = 1'b0;
        w_wr_addr = w_base_tos;
        case (w_op)
            RAS_PUSH: begin
                w_nxt_tos = w_base_tos + PW'(1);
                w_wr_addr = w_base_tos + PW'(1);
                w_we      = 1'b1;
                if (w_base_cnt != CNT_FULL) begin
                    w_nxt_cnt = w_base_cnt + CW'(1);
                end
            end
            RAS_POP: begin
                w_nxt_tos = w_base_tos - PW'(1);
                if (w_base_cnt != '0) begin
                    w_nxt_cnt = w_base_cnt - CW'(1);
                end
            end
            RAS_REPL: begin
                w_we = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tos <= '0;
            r_cnt <= '0;
        end else begin
            r_tos <= w_nxt_tos;
            r_cnt <= w_nxt_cnt;
        end
    end

    gs232c_ras_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (w_wr_addr),
        .i_wdata (w_wr_pc),
        .i_raddr (r_tos),
        .o_rdata (w_mem_rd)
    );

    assign fe_ckpt = {r_cnt, r_tos};

`ifdef GS232C_RAS_PUSH_BYPASS_EN
    logic w_byp;
    // Any write this cycle lands on the new top, so forward its data directly.
    assign w_byp    = w_we & ~reset;
    assign ra       = w_byp ? w_wr_pc : w_mem_rd;
    assign ra_valid = w_byp | (r_cnt != '0);
`else
    assign ra       = w_mem_rd;
    assign ra_valid = (r_cnt != '0);
`endif

endmodule

// File: tb/tb_gs232c_ras.sv
// Directed scoreboard bench for gs232c_ras (DEPTH=8, AW=30); bypass expectations follow
// GS232C_RAS_PUSH_BYPASS_EN.
module tb_gs232c_ras;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 30;
    localparam int unsigned PW    = 3;
    localparam int unsigned CW    = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             iq_go = 1'b0;
    logic             iq_cancel = 1'b0;
    logic             fe_push = 1'b0;
    logic [AW-1:0]    fe_push_pc = '0;
    logic             fe_pop = 1'b0;
    logic [PW+CW-1:0] fe_ckpt;
    logic             pr_cancel = 1'b0;
    logic [PW+CW-1:0] pr_ckpt = '0;
    logic             pr_link = 1'b0;
    logic [AW-1:0]    pr_link_pc = '0;
    logic             pr_jrra = 1'b0;
    logic [AW-1:0]    ra;
    logic             ra_valid;

    gs232c_ras #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iq_go      (iq_go),
        .iq_cancel  (iq_cancel),
        .fe_push    (fe_push),
        .fe_push_pc (fe_push_pc),
        .fe_pop     (fe_pop),
        .fe_ckpt    (fe_ckpt),
        .pr_cancel  (pr_cancel),
        .pr_ckpt    (pr_ckpt),
        .pr_link    (pr_link),
        .pr_link_pc (pr_link_pc),
        .pr_jrra    (pr_jrra),
        .ra         (ra),
        .ra_valid   (ra_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        string          tag;
        logic [AW-1:0]  ra;
        logic           vld;
        logic [CW-1:0]  cnt;
        bit             has_tos;
        logic [PW-1:0]  tos;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    logic [PW+CW-1:0] saved_ckpt;

    task automatic expect_state(input string tag, input logic [AW-1:0] ra_e, input logic v_e,
                                input logic [CW-1:0] c_e, input bit ht, input logic [PW-1:0] t_e);
        exp_t e;
        e.tag = tag; e.ra = ra_e; e.vld = v_e; e.cnt = c_e; e.has_tos = ht; e.tos = t_e;
        sbq.push_back(e);
    endtask

    task automatic check_head();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: got 0 entries, required 1");
            return;
        end
        e = sbq.pop_front();
        checks++;
        assert (ra === e.ra) else begin
            errors++;
            $error("FAIL %s ra: got %h required %h", e.tag, ra, e.ra);
        end
        checks++;
        assert (ra_valid === e.vld) else begin
            errors++;
            $error("FAIL %s ra_valid: got %b required %b", e.tag, ra_valid, e.vld);
        end
        checks++;
        assert (fe_ckpt[PW +: CW] === e.cnt) else begin
            errors++;
            $error("FAIL %s cnt: got %0d required %0d", e.tag, fe_ckpt[PW +: CW], e.cnt);
        end
        if (e.has_tos) begin
            checks++;
            assert (fe_ckpt[PW-1:0] === e.tos) else begin
                errors++;
                $error("FAIL %s tos: got %0d required %0d", e.tag, fe_ckpt[PW-1:0], e.tos);
            end
        end
    endtask

    task automatic clear_inputs();
        iq_go = 1'b0; iq_cancel = 1'b0; fe_push = 1'b0; fe_pop = 1'b0;
        pr_cancel = 1'b0; pr_link = 1'b0; pr_jrra = 1'b0;
    endtask

    task automatic fe_step(input string tag, input logic push, input logic [AW-1:0] pc,
                           input logic pop, input logic [AW-1:0] ra_e, input logic v_e,
                           input logic [CW-1:0] c_e, input bit ht, input logic [PW-1:0] t_e);
        iq_go = 1'b1; fe_push = push; fe_push_pc = pc; fe_pop = pop;
        expect_state(tag, ra_e, v_e, c_e, ht, t_e);
        @(posedge clock); #1;
        clear_inputs();
        check_head();
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        expect_state("reset", '0, 1'b0, '0, 1'b1, '0);
        check_head();
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        // Basic push/pop
        fe_step("push100", 1, 30'h100, 0, 30'h100, 1, 4'd1, 1, 3'd1);
        fe_step("push200", 1, 30'h200, 0, 30'h200, 1, 4'd2, 1, 3'd2);
        fe_step("pop1",    0, '0,      1, 30'h100, 1, 4'd1, 1, 3'd1);
        fe_step("pop0",    0, '0,      1, '0,      0, 4'd0, 1, 3'd0);

        // Overflow: 9 pushes into 8 entries; the 9th overwrites the oldest
        for (int k = 1; k <= 9; k++) begin
            fe_step($sformatf("ovf_push%0d", k), 1, AW'(k), 0, AW'(k), 1,
                    CW'((k > 8) ? 8 : k), 1, PW'(k % 8));
        end
        for (int i = 1; i <= 7; i++) begin
            fe_step($sformatf("ovf_pop%0d", i), 0, '0, 1, AW'(9 - i), 1, CW'(8 - i), 0, '0);
        end
        fe_step("ovf_pop8", 0, '0, 1, 30'd9, 0, 4'd0, 1, 3'd1);
        fe_step("ovf_pop9", 0, '0, 1, 30'd8, 0, 4'd0, 1, 3'd0);

        // Underflow then recover
        fe_step("udf_pop",  0, '0,     1, 30'd7,  0, 4'd0, 1, 3'd7);
        fe_step("udf_push", 1, 30'h55, 0, 30'h55, 1, 4'd1, 1, 3'd0);

        // Same-cycle push and pop replaces top
        fe_step("pre_repl", 1, 30'h66,  0, 30'h66,  1, 4'd2, 1, 3'd1);
        fe_step("repl",     1, 30'h300, 1, 30'h300, 1, 4'd2, 1, 3'd1);

        // Async reset mid-stream takes effect before the next edge
        reset = 1'b1;
        #1;
        expect_state("mid_reset", '0, 1'b0, '0, 1'b1, '0);
        check_head();
        @(posedge clock); #1;
        reset = 1'b0;

        // Checkpoint repair
        fe_step("pushA", 1, 30'hA, 0, 30'hA, 1, 4'd1, 1, 3'd1);
        fe_step("pushB", 1, 30'hB, 0, 30'hB, 1, 4'd2, 1, 3'd2);
        saved_ckpt = fe_ckpt;
        checks++;
        assert (saved_ckpt === 7'b0010_010) else begin
            errors++;
            $error("FAIL ckpt_save: got %b required %b", saved_ckpt, 7'b0010_010);
        end
        fe_step("popB", 0, '0, 1, 30'hA, 1, 4'd1, 1, 3'd1);
        fe_step("popA", 0, '0, 1, '0,    0, 4'd0, 1, 3'd0);

        pr_cancel = 1'b1; pr_ckpt = saved_ckpt; pr_link = 1'b1; pr_link_pc = 30'hC;
        iq_go = 1'b1; fe_push = 1'b1; fe_push_pc = 30'hDD;
        expect_state("repair_link", 30'hC, 1, 4'd3, 1, 3'd3);
        @(posedge clock); #1;
        clear_inputs();
        check_head();
        fe_step("post_repair_pop", 0, '0, 1, 30'hB, 1, 4'd2, 1, 3'd2);

        pr_cancel = 1'b1; pr_ckpt = saved_ckpt; pr_jrra = 1'b1;
        expect_state("repair_jrra", 30'hA, 1, 4'd1, 1, 3'd1);
        @(posedge clock); #1;
        clear_inputs();
        check_head();

        // Unqualified pushes are ignored
        iq_go = 1'b1; iq_cancel = 1'b1; fe_push = 1'b1; fe_push_pc = 30'hEE;
        expect_state("iq_cancel", 30'hA, 1, 4'd1, 1, 3'd1);
        @(posedge clock); #1;
        clear_inputs();
        check_head();
        iq_go = 1'b0; fe_push = 1'b1; fe_push_pc = 30'hEF;
        expect_state("no_go", 30'hA, 1, 4'd1, 1, 3'd1);
        @(posedge clock); #1;
        clear_inputs();
        check_head();

        // Same-cycle visibility of a push
        iq_go = 1'b1; fe_push = 1'b1; fe_push_pc = 30'h77;
`ifdef GS232C_RAS_PUSH_BYPASS_EN
        expect_state("byp_comb", 30'h77, 1, 4'd1, 1, 3'd1);
`else
        expect_state("byp_comb", 30'hA, 1, 4'd1, 1, 3'd1);
`endif
        #1;
        check_head();
        expect_state("byp_reg", 30'h77, 1, 4'd2, 1, 3'd2);
        @(posedge clock); #1;
        clear_inputs();
        check_head();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
